// File: rtl/pulse_peak_detector_if.sv
// Event output channel of the pulse peak detector: one valid/ready register
// carrying the extracted pulse fields.
interface pulse_peak_detector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 32,
  parameter int WIDTH_BITS = 8
);
  logic                         peak_valid;
  logic                         peak_ready;
  logic signed [DATA_WIDTH-1:0] peak_amplitude;
  logic [TS_WIDTH-1:0]          peak_time;
  logic [WIDTH_BITS-1:0]        peak_width;
  logic                         peak_truncated;
  logic                         peak_pileup;

  modport master (
    output peak_valid, peak_amplitude, peak_time, peak_width,
           peak_truncated, peak_pileup,
    input  peak_ready
  );

  modport slave (
    input  peak_valid, peak_amplitude, peak_time, peak_width,
           peak_truncated, peak_pileup,
    output peak_ready
  );
endinterface

// File: rtl/pulse_peak_detector.sv
// Threshold-crossing pulse detector on the trapezoidal filter stream; emits one
// event (peak, peak time, width, flags) per pulse through a single-entry register.
module pulse_peak_detector #(
  parameter int DATA_WIDTH     = 16,
  parameter int TS_WIDTH       = 32,
  parameter int WIDTH_BITS     = 8,
  parameter int MAX_WIDTH      = 255,
  parameter int HYST           = 10,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int DROP_BITS      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] filter_data,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  pulse_peak_detector_if.master        peak,
  output logic [DROP_BITS-1:0]         drop_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF, REARM} state_t;

  localparam int HC_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic signed [DATA_WIDTH:0] HYST_EXT  = (DATA_WIDTH+1)'(HYST);
  localparam logic [WIDTH_BITS-1:0]      MAX_W     = WIDTH_BITS'(MAX_WIDTH);
  localparam logic [HC_W-1:0]            HOLD_LOAD = HC_W'(HOLDOFF_CYCLES - 1);

  state_t                       state;
  logic [TS_WIDTH-1:0]          ts;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [TS_WIDTH-1:0]          tmax_q;
  logic [WIDTH_BITS-1:0]        width_q;
  logic [HC_W-1:0]              hold_cnt;
  logic                         pileup_pending;

  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_amplitude;
  logic [TS_WIDTH-1:0]          out_time;
  logic [WIDTH_BITS-1:0]        out_width;
  logic                         out_truncated;
  logic                         out_pileup;

  // One extra bit keeps threshold - HYST from wrapping near the negative limit.
  logic signed [DATA_WIDTH:0] thr_ext;
  logic signed [DATA_WIDTH:0] sample_ext;
  logic signed [DATA_WIDTH:0] end_level;
  logic                       start_hit;
  logic                       end_hit;
  logic                       above_end;

  assign thr_ext    = {threshold[DATA_WIDTH-1], threshold};
  assign sample_ext = {filter_data[DATA_WIDTH-1], filter_data};
  assign end_level  = thr_ext - HYST_EXT;
  assign start_hit  = filter_data > threshold;
  assign end_hit    = sample_ext < end_level;
  assign above_end  = sample_ext > end_level;

  logic                         close;
  logic                         close_trunc;
  logic signed [DATA_WIDTH-1:0] upd_max;
  logic [TS_WIDTH-1:0]          upd_tmax;
  logic [WIDTH_BITS-1:0]        upd_width;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    close       = 1'b0;
    close_trunc = 1'b0;
    upd_max     = max_q;
    upd_tmax    = tmax_q;
    upd_width   = width_q;
    if (state == ACTIVE) begin
      if (end_hit) begin
        close = 1'b1;
      end else begin
        upd_width = width_q + 1'b1;
        if (filter_data > max_q) begin
          upd_max  = filter_data;
          upd_tmax = ts;
        end
        if (upd_width == MAX_W) begin
          close       = 1'b1;
          close_trunc = 1'b1;
        end
      end
    end
  end

  // NOTE: all state here is updated with <= so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      ts             <= '0;
      max_q          <= '0;
      tmax_q         <= '0;
      width_q        <= '0;
      hold_cnt       <= '0;
      pileup_pending <= 1'b0;
      out_valid      <= 1'b0;
      out_amplitude  <= '0;
      out_time       <= '0;
      out_width      <= '0;
      out_truncated  <= 1'b0;
      out_pileup     <= 1'b0;
      drop_count     <= '0;
    end else begin
      ts <= ts + 1'b1;

      case (state)
        IDLE: begin
          if (start_hit) begin
            state   <= ACTIVE;
            max_q   <= filter_data;
            tmax_q  <= ts;
            width_q <= WIDTH_BITS'(1);
          end
        end
        ACTIVE: begin
          max_q   <= upd_max;
          tmax_q  <= upd_tmax;
          width_q <= upd_width;
          if (close) begin
            state    <= (HOLDOFF_CYCLES == 0) ? REARM : HOLDOFF;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLDOFF: begin
          if (start_hit) pileup_pending <= 1'b1;
          if (hold_cnt == '0) state <= REARM;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        REARM: begin
          if (!above_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A close consumes the pending pileup flag whether the event lands or drops.
      if (close) begin
        pileup_pending <= 1'b0;
        if (!out_valid || peak.peak_ready) begin
          out_valid     <= 1'b1;
          out_amplitude <= upd_max;
          out_time      <= upd_tmax;
          out_width     <= upd_width;
          out_truncated <= close_trunc;
          out_pileup    <= pileup_pending;
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (out_valid && peak.peak_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign peak.peak_valid     = out_valid;
  assign peak.peak_amplitude = out_amplitude;
  assign peak.peak_time      = out_time;
  assign peak.peak_width     = out_width;
  assign peak.peak_truncated = out_truncated;
  assign peak.peak_pileup    = out_pileup;

endmodule
